// File: rtl/freq_gen.sv
// Programmable 50% duty square-wave generator: a sequential restoring divider turns a
// requested frequency into a half-period count, applied only at half-period boundaries.
module freq_gen #(
    parameter int CLK_HZ = 100000000,
    parameter int FW     = 20,
    parameter int CW     = 27,
    parameter int MAX_HZ = 999999
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [FW-1:0] freq_in,
    input  logic          load,
    output logic          busy,
    output logic          err,
    output logic          active,
    output logic          sig_out
);

    localparam int             RW       = FW + 1;
    localparam int             IW       = $clog2(CW);
    localparam logic [CW-1:0]  DIVIDEND = CW'(CLK_HZ);
    localparam logic [FW-1:0]  MAX_F    = FW'(MAX_HZ);

    typedef enum logic [1:0] {
        S_IDLE,
        S_DIV,
        S_COMMIT
    } state_t;

    state_t         state;
    state_t         state_nx;

    logic [RW-1:0]  dvsr;
    logic [RW-1:0]  rem;
    logic [CW-1:0]  quot;
    logic [IW-1:0]  bit_idx;
    logic [RW:0]    rem_sh;
    logic           take;

    logic [CW-1:0]  pend_n;
    logic           pend_valid;
    logic [CW-1:0]  n_cur;
    logic [CW-1:0]  cnt;
    logic           at_end;

    assign rem_sh = {rem, DIVIDEND[bit_idx]};
    assign take   = (rem_sh >= {1'b0, dvsr});
    assign at_end = active && (cnt == n_cur - 1'b1);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // A zero request skips the division and commits a zero half-period straight away.
    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE: begin
                if (load && !busy && (freq_in <= MAX_F)) begin
                    state_nx = (freq_in == '0) ? S_COMMIT : S_DIV;
                end
            end
            S_DIV: begin
                if (bit_idx == '0) begin
                    state_nx = S_COMMIT;
                end
            end
            S_COMMIT: state_nx = S_IDLE;
            default:  state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            busy    <= 1'b0;
            err     <= 1'b0;
            dvsr    <= '0;
            rem     <= '0;
            quot    <= '0;
            bit_idx <= '0;
        end else begin
            busy <= (state_nx != S_IDLE);
            if (state == S_IDLE && load) begin
                if (freq_in > MAX_F) begin
                    err <= 1'b1;
                end else begin
                    err     <= 1'b0;
                    dvsr    <= {freq_in, 1'b0};
                    rem     <= '0;
                    quot    <= '0;
                    bit_idx <= IW'(CW - 1);
                end
            end
            if (state == S_DIV) begin
                rem     <= take ? RW'(rem_sh - {1'b0, dvsr}) : rem_sh[RW-1:0];
                quot    <= {quot[CW-2:0], take};
                bit_idx <= bit_idx - 1'b1;
            end
        end
    end

    // A fresh commit outranks clearing the flag, so the newest request always survives.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pend_n     <= '0;
            pend_valid <= 1'b0;
            n_cur      <= '0;
            cnt        <= '0;
            active     <= 1'b0;
            sig_out    <= 1'b0;
        end else begin
            if (state == S_COMMIT) begin
                pend_n     <= quot;
                pend_valid <= 1'b1;
            end else if (pend_valid && (!active || at_end)) begin
                pend_valid <= 1'b0;
            end

            if (!active) begin
                if (pend_valid && pend_n != '0) begin
                    active <= 1'b1;
                    n_cur  <= pend_n;
                    cnt    <= '0;
                end
            end else if (at_end) begin
                cnt <= '0;
                if (pend_valid && pend_n == '0) begin
                    active  <= 1'b0;
                    sig_out <= 1'b0;
                    n_cur   <= '0;
                end else begin
                    sig_out <= ~sig_out;
                    if (pend_valid) begin
                        n_cur <= pend_n;
                    end
                end
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_freq_gen.sv
// Bench for freq_gen: a cycle model built from integer division and a countdown to the
// next boundary, checked every cycle, plus hand-computed timing expectations.
module tb_freq_gen;

    localparam int CLK_HZ = 100000000;
    localparam int FW     = 20;
    localparam int CW     = 27;
    localparam int MAX_HZ = 999999;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [FW-1:0] freq_in = '0;
    logic          load = 1'b0;
    logic          busy;
    logic          err;
    logic          active;
    logic          sig_out;

    int tests = 0;
    int fails = 0;
    int skip_to = 0;

    int   m_busy_left = 0;
    int   m_req = 0;
    int   m_pn = 0;
    int   m_ncur = 0;
    int   m_left = 0;
    logic m_err = 1'b0;
    logic m_active = 1'b0;
    logic m_sig = 1'b0;
    logic m_pv = 1'b0;

    freq_gen #(
        .CLK_HZ(CLK_HZ),
        .FW(FW),
        .CW(CW),
        .MAX_HZ(MAX_HZ)
    ) dut (
        .clk(clk),
        .rst(rst),
        .freq_in(freq_in),
        .load(load),
        .busy(busy),
        .err(err),
        .active(active),
        .sig_out(sig_out)
    );

    always #5 clk = ~clk;

    // Reference model: the half-period is CLK_HZ/(2f) by plain division, and the wave
    // is tracked as cycles remaining until the next half-period boundary.
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_busy_left = 0;
            m_req = 0;
            m_pn = 0;
            m_ncur = 0;
            m_left = 0;
            m_err = 1'b0;
            m_active = 1'b0;
            m_sig = 1'b0;
            m_pv = 1'b0;
        end else begin
            if (!m_active) begin
                if (m_pv) begin
                    m_pv = 1'b0;
                    if (m_pn > 0) begin
                        m_active = 1'b1;
                        m_ncur = m_pn;
                        m_left = m_pn;
                    end
                end
            end else begin
                if (skip_to > 0) m_left = skip_to;
                m_left = m_left - 1;
                if (m_left == 0) begin
                    if (m_pv && m_pn == 0) begin
                        m_active = 1'b0;
                        m_sig = 1'b0;
                    end else begin
                        m_sig = ~m_sig;
                        if (m_pv) m_ncur = m_pn;
                    end
                    m_pv = 1'b0;
                    m_left = m_ncur;
                end
            end
            if (m_busy_left > 0) begin
                m_busy_left = m_busy_left - 1;
                if (m_busy_left == 0) begin
                    m_pn = m_req;
                    m_pv = 1'b1;
                end
            end else if (load) begin
                if (int'(freq_in) > MAX_HZ) begin
                    m_err = 1'b1;
                end else begin
                    m_err = 1'b0;
                    m_req = (freq_in == 0) ? 0 : CLK_HZ / (2 * int'(freq_in));
                    m_busy_left = (freq_in == 0) ? 1 : CW + 1;
                end
            end
        end
    end

    task automatic checkOutput(input string name, input longint got, input longint exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    // Every cycle the DUT outputs are compared against the model at the falling edge.
    task automatic tick();
        logic [3:0] got;
        logic [3:0] exp;
        @(negedge clk);
        got = {busy, err, active, sig_out};
        exp = {(m_busy_left != 0), m_err, m_active, m_sig};
        tests++;
        if (got !== exp) begin
            fails++;
            $display("[TB] FAIL model_cmp at %0t: busy/err/active/sig got %b expected %b",
                     $time, got, exp);
        end
    endtask

    task automatic applyStimulus(input int f);
        freq_in = f[FW-1:0];
        load = 1'b1;
        tick();
        load = 1'b0;
    endtask

    task automatic waitSig(input logic lvl, input int budget, output int n);
        n = 0;
        while (sig_out !== lvl && n < budget) begin
            tick();
            n++;
        end
    endtask

    task automatic waitBusy(output int n);
        n = 0;
        while (busy === 1'b1 && n < 100) begin
            tick();
            n++;
        end
    endtask

    task automatic forceNearEnd(input int back);
        force dut.cnt = CW'(50000000 - back);
        skip_to = back;
        #1;
        release dut.cnt;
        tick();
        skip_to = 0;
    endtask

    initial begin
        int n;

        rst = 1'b0;
        repeat (3) tick();
        checkOutput("reset_busy", busy, 0);
        checkOutput("reset_err", err, 0);
        checkOutput("reset_active", active, 0);
        checkOutput("reset_sig", sig_out, 0);
        rst = 1'b1;
        tick();

        applyStimulus(500000);
        waitBusy(n);
        checkOutput("busy_len_500k", n, 28);
        checkOutput("active_before_start", active, 0);
        tick();
        checkOutput("active_rise", active, 1);
        checkOutput("sig_low_at_start", sig_out, 0);
        waitSig(1'b1, 300, n);
        checkOutput("first_rise_delay", n, 100);
        waitSig(1'b0, 300, n);
        checkOutput("high_time_500k", n, 100);
        waitSig(1'b1, 300, n);
        checkOutput("low_time_500k", n, 100);

        repeat (30) tick();
        applyStimulus(250000);
        waitSig(1'b0, 300, n);
        checkOutput("old_half_completes", 31 + n, 100);
        waitSig(1'b1, 400, n);
        checkOutput("low_time_250k", n, 200);
        waitSig(1'b0, 400, n);
        checkOutput("high_time_250k", n, 200);

        applyStimulus(1000000);
        checkOutput("err_set", err, 1);
        checkOutput("err_no_busy", busy, 0);
        checkOutput("err_still_active", active, 1);
        repeat (5) tick();
        checkOutput("err_sticky", err, 1);

        applyStimulus(500000);
        checkOutput("err_cleared", err, 0);
        checkOutput("busy_after_valid", busy, 1);
        waitBusy(n);
        checkOutput("busy_len_second", n, 28);
        waitSig(1'b1, 400, n);
        waitSig(1'b0, 300, n);
        checkOutput("high_time_back_500k", n, 100);

        applyStimulus(0);
        checkOutput("busy_f0", busy, 1);
        freq_in = FW'(250000);
        load = 1'b1;
        tick();
        load = 1'b0;
        checkOutput("busy_f0_one_cycle", busy, 0);
        tick();
        checkOutput("load_while_busy_ignored", busy, 0);
        n = 0;
        while (active === 1'b1 && n < 300) begin
            tick();
            n++;
        end
        checkOutput("stop_at_boundary", 3 + n, 100);
        checkOutput("stopped_sig_low", sig_out, 0);
        repeat (250) tick();
        checkOutput("stays_inactive", active, 0);
        checkOutput("stays_low", sig_out, 0);

        applyStimulus(1);
        waitBusy(n);
        checkOutput("busy_len_f1", n, 28);
        tick();
        checkOutput("active_f1", active, 1);
        checkOutput("n_cur_f1", dut.n_cur, 50000000);
        forceNearEnd(5);
        waitSig(1'b1, 20, n);
        checkOutput("f1_rise_at_terminal", 1 + n, 5);
        forceNearEnd(3);
        waitSig(1'b0, 20, n);
        checkOutput("f1_fall_at_terminal", 1 + n, 3);
        forceNearEnd(2);
        waitSig(1'b1, 20, n);
        checkOutput("f1_rise_again", 1 + n, 2);

        applyStimulus(500000);
        repeat (3) tick();
        checkOutput("busy_before_reset", busy, 1);
        checkOutput("sig_before_reset", sig_out, 1);
        #2;
        rst = 1'b0;
        #1;
        checkOutput("async_busy", busy, 0);
        checkOutput("async_active", active, 0);
        checkOutput("async_sig", sig_out, 0);
        checkOutput("async_err", err, 0);
        tick();
        rst = 1'b1;
        repeat (300) tick();
        checkOutput("post_reset_idle", active, 0);
        checkOutput("post_reset_low", sig_out, 0);
        checkOutput("post_reset_not_busy", busy, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
